perspective_divider: RTL and testbench

Stream block that takes clip-space vertices (x, y, z, w), sends w to the `FixedReciprocalDivider` stream, and multiplies x, y, z by the returned 1/w to produce NDC coordinates. It is the initiator and consumer on both of the divider's stream ports. It buffers x, y, z in order while the divider works, so the divider's latency is hidden. It sits in the geometry pipeline between vertex transform and rasterizer setup.

---
 rtl/perspective_divider.sv | 141 ++++++++++++++
 tb/tb_perspective_divider.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perspective_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perspective_divider                                                      |
// | Clip-space to NDC stage: w goes out to a reciprocal divider, x/y/z wait  |
// | in a FIFO and are scaled by the returned 1/w with saturation.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package fixed_pkg;
    localparam int TOTAL_WIDTH   = 32;
    localparam int DECIMAL_WIDTH = 16;
    typedef logic signed [TOTAL_WIDTH-1:0] fixed;
endpackage

module perspective_divider
    import fixed_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          vertex_s_ready,
    input  logic                          vertex_s_valid,
    input  fixed [3:0]                    vertex_s_data,
    input  logic                          divisor_m_ready,
    output logic                          divisor_m_valid,
    output fixed                          divisor_m_data,
    output logic                          recip_s_ready,
    input  logic                          recip_s_valid,
    input  fixed                          recip_s_data,
    input  logic                          vertex_m_ready,
    output logic                          vertex_m_valid,
    output fixed [2:0]                    vertex_m_data,
    output logic [$clog2(MAX_INFLIGHT):0] pending,
    output logic                          idle,
    output logic                          order_error
);

    localparam int c_PTR_W = $clog2(MAX_INFLIGHT);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_PRD_W = 2 * TOTAL_WIDTH;
    localparam logic signed [c_PRD_W-1:0] c_SAT_HI = {{(TOTAL_WIDTH+1){1'b0}}, {(TOTAL_WIDTH-1){1'b1}}};
    localparam logic signed [c_PRD_W-1:0] c_SAT_LO = {{(TOTAL_WIDTH+1){1'b1}}, {(TOTAL_WIDTH-1){1'b0}}};

    fixed [2:0]          r_fifo [MAX_INFLIGHT];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_pending;
    logic                r_out_valid;
    fixed [2:0]          r_out_data;
    logic                r_order_error;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_recip_xfer;
    logic                w_pop;
    fixed [2:0]          w_head;
    fixed [2:0]          w_scaled;

    // Full-precision product, realign the binary point, clamp to the fixed range.
    function automatic fixed scale(input fixed coord, input fixed recip);
        logic signed [c_PRD_W-1:0] prod;
        logic signed [c_PRD_W-1:0] shifted;
        prod    = c_PRD_W'(coord) * c_PRD_W'(recip);
        shifted = prod >>> DECIMAL_WIDTH;
        if (shifted > c_SAT_HI) begin
            return c_SAT_HI[TOTAL_WIDTH-1:0];
        end else if (shifted < c_SAT_LO) begin
            return c_SAT_LO[TOTAL_WIDTH-1:0];
        end
        return shifted[TOTAL_WIDTH-1:0];
    endfunction

    // Issue side is gated by reset so no divisor escapes while the FIFO is cleared.
    assign w_full          = (r_pending == c_CNT_W'(MAX_INFLIGHT));
    assign w_empty         = (r_pending == '0);
    assign vertex_s_ready  = divisor_m_ready && !w_full && !reset;
    assign divisor_m_valid = vertex_s_valid && !w_full && !reset;
    assign divisor_m_data  = vertex_s_data[0];
    assign w_push          = vertex_s_valid && vertex_s_ready;

    assign recip_s_ready   = !r_out_valid || vertex_m_ready;
    assign w_recip_xfer    = recip_s_valid && recip_s_ready;
    assign w_pop           = w_recip_xfer && !w_empty;
    assign w_head          = r_fifo[r_rd_ptr];

    for (genvar i = 0; i < 3; i++) begin : g_scale
        assign w_scaled[i] = scale(w_head[i], recip_s_data);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= vertex_s_data[3:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pending     <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_order_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_pending <= r_pending + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_pending <= r_pending - c_CNT_W'(1);
            end

            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_scaled;
            end else if (vertex_m_ready) begin
                r_out_valid <= 1'b0;
            end

            // A reciprocal with nothing waiting means the pairing is lost.
            if (w_recip_xfer && w_empty) begin
                r_order_error <= 1'b1;
            end
        end
    end

    assign vertex_m_valid = r_out_valid;
    assign vertex_m_data  = r_out_data;
    assign pending        = r_pending;
    assign idle           = w_empty && !r_out_valid;
    assign order_error    = r_order_error;

endmodule

`default_nettype wire

// File: tb/tb_perspective_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_perspective_divider                                                   |
// | Directed bench with a latency-configurable in-order reciprocal model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_perspective_divider;
    import fixed_pkg::*;

    localparam int c_MAXF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vertex_s_ready;
    logic       vertex_s_valid = 1'b0;
    fixed [3:0] vertex_s_data = '0;
    logic       divisor_m_ready = 1'b1;
    logic       divisor_m_valid;
    fixed       divisor_m_data;
    logic       recip_s_ready;
    logic       recip_s_valid = 1'b0;
    fixed       recip_s_data = '0;
    logic       vertex_m_ready = 1'b1;
    logic       vertex_m_valid;
    fixed [2:0] vertex_m_data;
    logic [3:0] pending;
    logic       idle;
    logic       order_error;

    perspective_divider #(.MAX_INFLIGHT(c_MAXF)) dut (
        .clk(clk), .reset(reset),
        .vertex_s_ready(vertex_s_ready), .vertex_s_valid(vertex_s_valid), .vertex_s_data(vertex_s_data),
        .divisor_m_ready(divisor_m_ready), .divisor_m_valid(divisor_m_valid), .divisor_m_data(divisor_m_data),
        .recip_s_ready(recip_s_ready), .recip_s_valid(recip_s_valid), .recip_s_data(recip_s_data),
        .vertex_m_ready(vertex_m_ready), .vertex_m_valid(vertex_m_valid), .vertex_m_data(vertex_m_data),
        .pending(pending), .idle(idle), .order_error(order_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic fixed recip_of(input fixed w);
        longint q;
        q = 64'sd4294967296 / longint'(w);
        return fixed'(q[31:0]);
    endfunction

    function automatic fixed ndc(input fixed c, input fixed r);
        longint p;
        p = (longint'(c) * longint'(r)) >>> 16;
        if (p > 64'sd2147483647) return 32'sh7fffffff;
        if (p < -64'sd2147483648) return 32'sh80000000;
        return fixed'(p[31:0]);
    endfunction

    // Divider model: in-order, result valid lat cycles after the divisor is taken.
    typedef struct packed { fixed val; int due; } rq_t;
    rq_t  rq[$];
    int   cyc = 0;
    int   lat = 5;
    logic inject_req = 1'b0;
    logic bp_mode = 1'b0;

    always @(posedge clk) begin
        if (recip_s_valid && recip_s_ready) void'(rq.pop_front());
        if (divisor_m_valid && divisor_m_ready) rq.push_back('{val: recip_of(divisor_m_data), due: cyc + lat});
        if (inject_req) rq.push_back('{val: 32'sh10000, due: 0});
        cyc <= cyc + 1;
        if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
            recip_s_valid <= 1'b1;
            recip_s_data  <= rq[0].val;
        end else begin
            recip_s_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        vertex_m_ready  <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        divisor_m_ready <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output scoreboard and stall-hold monitor.
    fixed [2:0] exp_q[$];
    int         n_out = 0;
    logic       prev_stall = 1'b0;
    fixed [2:0] prev_data = '0;

    always @(posedge clk) begin
        if (!reset && vertex_m_valid && vertex_m_ready) begin
            n_out <= n_out + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_out", vertex_m_valid, 1'b0);
            end else begin
                check("out_x", vertex_m_data[2], exp_q[0][2]);
                check("out_y", vertex_m_data[1], exp_q[0][1]);
                check("out_z", vertex_m_data[0], exp_q[0][0]);
                void'(exp_q.pop_front());
            end
        end
        if (!reset && prev_stall) begin
            check("stall_hold", {vertex_m_valid, vertex_m_data}, {1'b1, prev_data});
        end
        prev_stall <= !reset && vertex_m_valid && !vertex_m_ready;
        prev_data  <= vertex_m_data;
    end

    task automatic send(input fixed x, input fixed y, input fixed z, input fixed w, input bit expect_out);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        vertex_s_data  = {x, y, z, w};
        vertex_s_valid = 1'b1;
        while (!acc && t < 500) begin
            @(posedge clk);
            acc = vertex_s_ready;
            @(negedge clk);
            t++;
        end
        vertex_s_valid = 1'b0;
        if (!acc) check("send_timeout", acc, 1'b1);
        else if (expect_out) exp_q.push_back({ndc(x, recip_of(w)), ndc(y, recip_of(w)), ndc(z, recip_of(w))});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && rq.size() == 0 && !recip_s_valid && idle) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_s_ready", vertex_s_ready, 1'b0);
        check("rst_div_valid", divisor_m_valid, 1'b0);
        check("rst_recip_ready", recip_s_ready, 1'b1);
        check("rst_m_valid", vertex_m_valid, 1'b0);
        check("rst_m_data", vertex_m_data, 96'd0);
        check("rst_pending", pending, 4'd0);
        check("rst_idle", idle, 1'b1);
        check("rst_order_error", order_error, 1'b0);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);

        // Basic: {2.0, -1.0, 0.5, 4.0} -> {0.5, -0.25, 0.125}
        base = n_out;
        exp_q.push_back({32'sh0000_8000, 32'shFFFF_C000, 32'sh0000_2000});
        send(32'sh0002_0000, 32'shFFFF_0000, 32'sh0000_8000, 32'sh0004_0000, 1'b0);
        drain();
        check("basic_count", n_out - base, 1);
        check("basic_idle", idle, 1'b1);
        check("basic_pending", pending, 4'd0);

        // Saturation with w = 0.25
        exp_q.push_back({32'sh7FFF_FFFF, 32'sh0000_0000, 32'sh0004_0000});
        send(32'sh7FFF_FFFF, 32'sh0000_0000, 32'sh0001_0000, 32'sh0000_4000, 1'b0);
        exp_q.push_back({32'sh8000_0000, 32'shFFFC_0000, 32'sh0000_0000});
        send(32'sh8000_0000, 32'shFFFF_0000, 32'sh0000_0000, 32'sh0000_4000, 1'b0);
        drain();

        // Full FIFO: 12 back-to-back, long divider latency
        lat  = 20;
        base = n_out;
        for (int k = 1; k <= 12; k++) begin
            send(fixed'(k * 32'sh0002_0000), fixed'(-k * 32'sh0000_8000), 32'sh0003_0000, fixed'(k * 32'sh0001_0000), 1'b1);
            if (k == 8) begin
                check("full_s_ready", vertex_s_ready, 1'b0);
                check("full_pending", pending, 4'd8);
            end
        end
        drain();
        check("full_count", n_out - base, 12);

        // Order error: reciprocal with nothing in flight
        lat  = 5;
        base = n_out;
        inject_req = 1'b1;
        @(negedge clk);
        inject_req = 1'b0;
        repeat (4) @(negedge clk);
        check("oe_set", order_error, 1'b1);
        check("oe_no_out", n_out - base, 0);
        send(32'sh0001_0000, 32'sh0002_0000, 32'sh0003_0000, 32'sh0002_0000, 1'b1);
        drain();
        check("oe_sticky", order_error, 1'b1);

        // Back-pressure: random ready on both the divider and downstream
        lat     = 3;
        bp_mode = 1'b1;
        base    = n_out;
        for (int k = 0; k < 100; k++) begin
            send(fixed'(int'($urandom_range(0, 32'h7FFFF)) - 32'sh40000),
                 fixed'(int'($urandom_range(0, 32'h7FFFF)) - 32'sh40000),
                 fixed'(int'($urandom_range(0, 32'h7FFFF)) - 32'sh40000),
                 fixed'($urandom_range(32'h8000, 32'h100000)), 1'b1);
        end
        drain();
        bp_mode = 1'b0;
        check("bp_count", n_out - base, 100);
        @(negedge clk);

        // Reset with four vertices in flight
        lat  = 10;
        base = n_out;
        for (int k = 1; k <= 4; k++) begin
            send(32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000, fixed'(k * 32'sh0001_0000), 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        check("rst_stray_oe", order_error, 1'b1);
        check("rst_no_out", n_out - base, 0);
        exp_q.push_back({32'sh0000_8000, 32'shFFFF_C000, 32'sh0000_2000});
        send(32'sh0002_0000, 32'shFFFF_0000, 32'sh0000_8000, 32'sh0004_0000, 1'b0);
        drain();
        check("rst_after_count", n_out - base, 1);
        check("rst_after_pending", pending, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
